// File: rtl/adc_display_scheduler.sv
// Refresh sequencer for the ADC-to-display path: averages a block of ADC samples
// per refresh tick, runs the BCD converter handshake and strobes the display register.
module adc_display_scheduler #(
  parameter int TICK_DIV     = 2_500_000,
  parameter int AVG_LOG2     = 4,
  parameter int ADC_W        = 12,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             hold_toggle,
  output logic             conv_start,
  output logic [ADC_W-1:0] conv_data,
  input  logic             conv_done,
  output logic             update_en,
  output logic [ADC_W-1:0] avg_out,
  output logic             hold,
  output logic             busy,
  output logic             timeout_err
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int TO_W   = $clog2(CONV_TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  SAMP_LAST = CNT_W'(NSAMP - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(CONV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_CONVERT,
    S_WAIT_CONV,
    S_UPDATE
  } state_t;

  state_t             r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_samp_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [ADC_W-1:0]   r_avg;
  logic               r_conv_start;
  logic               r_update_en;
  logic               r_hold;
  logic               r_busy;
  logic               r_timeout_err;
  logic               w_tick;

  // The tick counter free-runs; ticks that land outside IDLE are simply lost.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // NOTE: all state and outputs update with <= so every branch sees the
  // pre-edge values; pulse outputs default low and are raised only on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_samp_cnt    <= '0;
      r_to_cnt      <= '0;
      r_avg         <= '0;
      r_conv_start  <= 1'b0;
      r_update_en   <= 1'b0;
      r_hold        <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_conv_start <= 1'b0;
      r_update_en  <= 1'b0;
      r_hold       <= r_hold ^ hold_toggle;

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_acc      <= '0;
            r_samp_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (adc_valid) begin
            if (r_samp_cnt == SAMP_LAST) begin
              r_avg        <= ADC_W'((r_acc + ACC_W'(adc_data)) >> AVG_LOG2);
              r_conv_start <= 1'b1;
              r_state      <= S_CONVERT;
            end else begin
              r_acc      <= r_acc + ACC_W'(adc_data);
              r_samp_cnt <= r_samp_cnt + CNT_W'(1);
            end
          end
        end

        S_CONVERT: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_CONV;
        end

        S_WAIT_CONV: begin
          if (conv_done) begin
            // Use the hold value that will be visible during the UPDATE cycle,
            // so a toggle arriving with conv_done still counts for this refresh.
            r_update_en <= ~(r_hold ^ hold_toggle);
            r_state     <= S_UPDATE;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_UPDATE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The converter operand is the latest average; it only changes on entry to CONVERT.
  assign conv_start  = r_conv_start;
  assign conv_data   = r_avg;
  assign avg_out     = r_avg;
  assign update_en   = r_update_en;
  assign hold        = r_hold;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/adc_display_scheduler.md
Name: adc_display_scheduler

Overview:
Sequencer for the ADC-to-display datapath. On each refresh tick it collects a block of ADC samples and averages them. It then hands the average to the binary-to-BCD converter with a start/done handshake, and pulses the write enable of the display storage register. A hold control freezes the display without stalling the sampling and conversion loop.

Parameters:
TICK_DIV, 2_500_000, clk cycles per refresh tick (20 Hz at 50 MHz); minimum 2
AVG_LOG2, 4, log2 of samples averaged per refresh (16); range 0..6
ADC_W, 12, ADC sample width
CONV_TIMEOUT, 64, max cycles waiting for conv_done before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
adc_valid  in  1  one-cycle strobe: adc_data holds a new sample
adc_data  in  ADC_W  raw ADC sample
hold_toggle  in  1  one-cycle pulse from debounced button; toggles hold
conv_start  out  1  one-cycle start pulse to the BCD converter
conv_data  out  ADC_W  averaged value presented to the converter
conv_done  in  1  one-cycle strobe: converter result valid
update_en  out  1  one-cycle write enable to the display storage register
avg_out  out  ADC_W  last computed average
hold  out  1  1 = display frozen
busy  out  1  1 = state != IDLE
timeout_err  out  1  sticky conversion-timeout flag

Behaviour:
- Reset (sync, high): state IDLE; tick counter, accumulator and sample counter cleared. All outputs 0, including hold and timeout_err.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = 1 for one cycle when count == TICK_DIV-1. Ticks arriving while state != IDLE are dropped and not queued.
- FSM states: IDLE, ACCUM, CONVERT, WAIT_CONV, UPDATE.
- IDLE: on tick, clear accumulator and sample count, go to ACCUM next cycle.
- ACCUM:
  - Each adc_valid adds adc_data to the accumulator (width ADC_W+AVG_LOG2; cannot overflow) and increments the count.
  - On the cycle the 2^AVG_LOG2-th sample is accepted, register avg_out = (acc + adc_data) >> AVG_LOG2 (truncating) at the same edge, then go to CONVERT.
  - adc_valid is ignored in all other states.
- CONVERT: conv_start = 1 for exactly this cycle. conv_data = avg_out, held stable until the next CONVERT. Next state is WAIT_CONV, with the timeout counter cleared.
- WAIT_CONV:
  - conv_done goes to UPDATE.
  - If the timeout counter reaches CONV_TIMEOUT with no conv_done, set timeout_err = 1 and return to IDLE with no update_en.
  - conv_done in any other state is ignored.
- UPDATE: update_en = 1 for this single cycle when hold == 0, else 0. Next state is IDLE.
- hold: toggles on every hold_toggle pulse in any state. It is sampled in the UPDATE cycle; a toggle that arrives in the UPDATE cycle takes effect from the next refresh.
- timeout_err: cleared only by reset.
- Latency, with back-to-back adc_valid: tick at cycle T, then ACCUM at T+1, samples accepted T+1..T+2^AVG_LOG2, conv_start at T+2^AVG_LOG2+1. conv_done at cycle C gives update_en at C+1.
- busy = 1 in all states except IDLE.
- Reset mid-operation: abort immediately to IDLE with all state cleared. No update_en or conv_start is issued from stale data.

Test Plan:
(Bench parameters: TICK_DIV=8, AVG_LOG2=2, CONV_TIMEOUT=16.)
1. Reset held 3 cycles, then released -> all outputs 0, busy=0; first tick is 7 cycles after release.
2. After tick, samples 100, 200, 300, 400 on consecutive cycles -> avg_out=250, conv_data=250, a single conv_start pulse. Drive conv_done 3 cycles later -> update_en high exactly 1 cycle, then busy=0.
3. Pulse hold_toggle -> hold=1; next full refresh -> conv_start issued, update_en stays 0. Second hold_toggle -> hold=0; following refresh produces update_en.
4. Never drive conv_done -> 16 cycles after entering WAIT_CONV, timeout_err=1, update_en never asserted, return to IDLE. Next refresh with conv_done completes normally and timeout_err stays 1.
5. Four samples of 4095 -> avg_out=4095 (no wrap). Samples 1, 1, 1, 2 -> avg_out=1 (truncation).
6. Reset asserted after 2 of 4 samples accepted -> IDLE, no conv_start. Next refresh with samples 8, 8, 8, 8 -> avg_out=8 (no stale contribution). A tick arriving during WAIT_CONV is dropped: only one conv_start per refresh.
